// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to binary converter (reverse double-dabble).
// One binary bit is resolved per clock after a one-cycle digit check.
// Optional feature macro: BCD2BIN_SIGN_EN adds sign_in and a signed two's-complement result.
module bcd_to_binary #(
  parameter int BIN_W = 8,
  parameter int BCD_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd_in,
`ifdef BCD2BIN_SIGN_EN
  input  logic             sign_in,
`endif
  output logic [BIN_W-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             err_digit,
  output logic             err_range
);

  // Number of full 4-bit digits; any leftover MS bits form a partial digit.
  localparam int NDIG  = BCD_W / 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BIN_W-1:0] BIN_ZERO = {BIN_W{1'b0}};
  localparam logic [BCD_W-1:0] BCD_ZERO = {BCD_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [BCD_W-1:0] bcd_r;
  logic [BIN_W-1:0] bin_r;
  logic [CNT_W-1:0] cnt_r;
  logic             digit_err_r;
`ifdef BCD2BIN_SIGN_EN
  logic             sign_r;
`endif

  logic [BCD_W+BIN_W-1:0] shift_s;
  logic [BIN_W-1:0]       result_s;
  logic                   range_err_s;

  // True when any full nibble holds a non-decimal code; the partial digit is never checked.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // One reverse double-dabble step: shift right, then pull every full nibble >= 8 back by 3.
  function automatic logic [BCD_W+BIN_W-1:0] dabble_step(input logic [BCD_W-1:0] b,
                                                         input logic [BIN_W-1:0] n);
    logic [BCD_W+BIN_W-1:0] cat;
    cat = {b, n} >> 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (cat[BIN_W+4*i +: 4] >= 4'd8) begin
        cat[BIN_W+4*i +: 4] = cat[BIN_W+4*i +: 4] - 4'd3;
      end else begin
        cat[BIN_W+4*i +: 4] = cat[BIN_W+4*i +: 4];
      end
    end
    return cat;
  endfunction

  // Next shift value and the final result/range decision taken from the post-shift registers.
  always_comb begin
    shift_s = dabble_step(bcd_r, bin_r);
`ifdef BCD2BIN_SIGN_EN
    if (sign_r) begin
      // Negative magnitudes up to 2^(BIN_W-1) fit: remainder zero and either MSB clear or exactly the MSB.
      range_err_s = !((bcd_r == BCD_ZERO) &&
                      (!bin_r[BIN_W-1] || (bin_r[BIN_W-2:0] == {(BIN_W-1){1'b0}})));
      if (range_err_s) begin
        result_s = bin_r;
      end else begin
        result_s = ~bin_r + {{(BIN_W-1){1'b0}}, 1'b1};
      end
    end else begin
      range_err_s = !((bcd_r == BCD_ZERO) && !bin_r[BIN_W-1]);
      result_s    = bin_r;
    end
`else
    range_err_s = (bcd_r != BCD_ZERO);
    result_s    = bin_r;
`endif
  end

  // Converter FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bcd_r       <= BCD_ZERO;
      bin_r       <= BIN_ZERO;
      cnt_r       <= {CNT_W{1'b0}};
      digit_err_r <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
      sign_r      <= 1'b0;
`endif
      bin_out     <= BIN_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_digit   <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            bcd_r       <= bcd_in;
`ifdef BCD2BIN_SIGN_EN
            sign_r      <= sign_in;
`endif
            bin_r       <= BIN_ZERO;
            cnt_r       <= {CNT_W{1'b0}};
            digit_err_r <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ST_CHECK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          digit_err_r <= has_bad_digit(bcd_r);
          state_r     <= has_bad_digit(bcd_r) ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          {bcd_r, bin_r} <= shift_s;
          cnt_r          <= cnt_r + CNT_ONE;
          state_r        <= (cnt_r == CNT_LAST) ? ST_DONE : ST_SHIFT;
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          if (digit_err_r) begin
            bin_out   <= BIN_ZERO;
            err_digit <= 1'b1;
            err_range <= 1'b0;
          end else begin
            bin_out   <= result_s;
            err_digit <= 1'b0;
            err_range <= range_err_s;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: randomized scoreboard bench for bcd_to_binary.
// Expected results come from a decimal-arithmetic model; a monitor checks every done pulse.
module tb_bcd_to_binary;

  localparam int BIN_W = 8;
  localparam int BCD_W = 10;
  localparam int NDIG  = BCD_W / 4;
`ifdef BCD2BIN_SIGN_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             ed;
    logic             er;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BCD_W-1:0] bcd_in = '0;
  logic             sign = 1'b0;
  logic [BIN_W-1:0] bin_out;
  logic             busy, done, err_digit, err_range;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t q[$];

  bcd_to_binary #(.BIN_W(BIN_W), .BCD_W(BCD_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
`ifdef BCD2BIN_SIGN_EN
    .sign_in(sign),
`endif
    .bin_out(bin_out), .busy(busy), .done(done),
    .err_digit(err_digit), .err_range(err_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decode the decimal value, then apply the range rules.
  function automatic exp_t model(input logic [BCD_W-1:0] b, input logic s);
    exp_t e;
    int   val = 0, mult = 1, lim;
    bit   bad = 0, neg;
    for (int i = 0; i < NDIG; i++) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) bad = 1;
      val += d * mult;
      mult *= 10;
    end
    val += int'(b >> (4*NDIG)) * mult;
    neg = s && SIGNED_MODE;
    if (bad) begin
      e.bin = '0; e.ed = 1'b1; e.er = 1'b0; e.cyc = 2;
    end else begin
      e.ed = 1'b0; e.cyc = BIN_W + 2;
      if (SIGNED_MODE) lim = neg ? (1 << (BIN_W-1)) : (1 << (BIN_W-1)) - 1;
      else             lim = (1 << BIN_W) - 1;
      e.er = (val > lim);
      if (e.er || !neg) e.bin = BIN_W'(val % (1 << BIN_W));
      else              e.bin = BIN_W'(((1 << BIN_W) - val) % (1 << BIN_W));
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("bin_out", bin_out, e.bin);
        check("err_digit", err_digit, e.ed);
        check("err_range", err_range, e.er);
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  // Issue one start (DUT known idle); hold start for up to 'hold' extra edges, which must be ignored.
  task automatic issue(input logic [BCD_W-1:0] b, input logic s, input int hold, output int tgt);
    exp_t e;
    int   h;
    tgt = done_cnt + 1;
    @(negedge clk);
    bcd_in = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    e = model(b, s);
    h = (hold > e.cyc) ? e.cyc : hold;
    e.cyc = e.cyc + cyc;
    q.push_back(e);
    check("busy_after_start", busy, 1'b1);
    repeat (h) @(posedge clk);
    @(negedge clk);
    start = 1'b0; bcd_in = BCD_W'($urandom); sign = 1'($urandom);
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 40 && done_cnt < tgt; i++) @(posedge clk);
    check("done_timeout", (done_cnt >= tgt), 1'b1);
  endtask

  task automatic conv(input logic [BCD_W-1:0] b, input logic s);
    int tgt;
    issue(b, s, 0, tgt);
    wait_done(tgt);
  endtask

  initial begin
    int tgt;
    exp_t e;
    logic [BCD_W-1:0] b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bin_out", bin_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_errs", {err_digit, err_range}, 2'b00);
    @(negedge clk) rst_n = 1'b1;

    conv(10'b10_0101_0101, 1'b0);   // 255
    conv(10'b10_0101_0110, 1'b0);   // 256
    conv(10'b00_1010_0011, 1'b0);   // tens digit A
    conv(10'b11_1001_1001, 1'b0);   // 399
    conv(10'b00_0000_0000, 1'b0);   // 0
    conv(10'b01_0010_0111, 1'b0);   // 127
    conv(10'b01_0010_1000, 1'b0);   // 128

    // Start held high: back-to-back conversions of 042, extra starts ignored.
    tgt = done_cnt + 1;
    @(negedge clk);
    bcd_in = 10'b00_0100_0010; sign = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      e = model(10'b00_0100_0010, 1'b0);
      e.cyc = e.cyc + cyc;
      q.push_back(e);
      if (k < 2) repeat (BIN_W + 2) @(posedge clk);
    end
    @(negedge clk) start = 1'b0;
    wait_done(tgt + 2);

    // Reset in the middle of shifting 199 aborts it.
    issue(10'b01_1001_1001, 1'b0, 0, tgt);
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_bin_out", bin_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_errs", {err_digit, err_range}, 2'b00);
    q.delete();
    tgt = done_cnt;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("no_done_after_rst", done_cnt, tgt);
    conv(10'b01_1001_1001, 1'b0);

`ifdef BCD2BIN_SIGN_EN
    conv(10'b01_0010_1000, 1'b1);   // -128
    conv(10'b01_0010_1001, 1'b1);   // -129
    conv(10'b01_0010_1000, 1'b0);   // +128
    conv(10'b00_0000_0101, 1'b1);   // -5
    conv(10'b00_0000_0000, 1'b1);   // -0
`endif

    // Randomized traffic with random ignored-start holds and idle gaps.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) b = BCD_W'($urandom);
      else b = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      issue(b, 1'($urandom), $urandom_range(0, 10), tgt);
      wait_done(tgt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
